mem_arbiter: RTL and testbench

Two-port round-robin arbiter that shares the single-port 32-bit data / 16-bit address word memory (Mem_D32b_A16b) between the CPU (port 0) and a DMA/program-loader engine (port 1). It sits between both masters and the memory's address, write-data, write-enable and read-data pins. Each master uses a request/grant/done handshake, and the arbiter serialises all accesses through a fixed four-state sequence.

---
 rtl/mem_arbiter.sv | 145 ++++++++++++++
 tb/tb_mem_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter sharing one single-port word memory between the CPU (port 0)
// and the DMA engine (port 1); every access runs the fixed IDLE/ISSUE/WAIT/DONE sequence.
module mem_arbiter #(
  parameter int unsigned BITS_DATA = 32,
  parameter int unsigned BITS_ADDR = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req0,
  input  logic                 req1,
  input  logic                 we0,
  input  logic                 we1,
  input  logic [BITS_ADDR-1:0] addr0,
  input  logic [BITS_ADDR-1:0] addr1,
  input  logic [BITS_DATA-1:0] wdata0,
  input  logic [BITS_DATA-1:0] wdata1,
  output logic                 gnt0,
  output logic                 gnt1,
  output logic                 done0,
  output logic                 done1,
  output logic [BITS_DATA-1:0] rdata0,
  output logic [BITS_DATA-1:0] rdata1,
  output logic                 busy,
  output logic [BITS_ADDR-1:0] mem_addr,
  output logic [BITS_DATA-1:0] mem_wdata,
  output logic                 mem_write,
  input  logic [BITS_DATA-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2,
    StDone  = 2'd3
  } state_e;

  state_e r_state, w_state_next;

  logic                 r_prio;
  logic                 r_owner;
  logic                 r_we;
  logic                 r_mem_write;
  logic [BITS_ADDR-1:0] r_mem_addr;
  logic [BITS_DATA-1:0] r_mem_wdata;
  logic                 r_gnt0, r_gnt1;
  logic                 r_done0, r_done1;
  logic [BITS_DATA-1:0] r_rdata0, r_rdata1;

  logic w_grant;
  logic w_winner;

  // prio only breaks ties; a lone requester wins regardless of whose turn it is
  always_comb begin
    w_grant  = 1'b0;
    w_winner = 1'b0;
    if (req0 && req1) begin
      w_grant  = 1'b1;
      w_winner = r_prio;
    end else if (req0) begin
      w_grant  = 1'b1;
      w_winner = 1'b0;
    end else if (req1) begin
      w_grant  = 1'b1;
      w_winner = 1'b1;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle:  if (w_grant) w_state_next = StIssue;
      StIssue: w_state_next = StWait;
      StWait:  w_state_next = StDone;
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_prio      <= 1'b0;
      r_owner     <= 1'b0;
      r_we        <= 1'b0;
      r_mem_write <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_gnt0      <= 1'b0;
      r_gnt1      <= 1'b0;
      r_done0     <= 1'b0;
      r_done1     <= 1'b0;
      r_rdata0    <= '0;
      r_rdata1    <= '0;
    end else begin
      r_gnt0  <= 1'b0;
      r_gnt1  <= 1'b0;
      r_done0 <= 1'b0;
      r_done1 <= 1'b0;
      case (r_state)
        StIdle: begin
          if (w_grant) begin
            r_owner     <= w_winner;
            r_prio      <= ~w_winner;
            r_we        <= w_winner ? we1 : we0;
            r_mem_write <= w_winner ? we1 : we0;
            r_mem_addr  <= w_winner ? addr1 : addr0;
            r_mem_wdata <= w_winner ? wdata1 : wdata0;
            r_gnt0      <= ~w_winner;
            r_gnt1      <= w_winner;
          end
        end
        StIssue: r_mem_write <= 1'b0;
        StWait: begin
          // memory read data is valid during WAIT; writes leave rdata untouched
          if (!r_we) begin
            if (r_owner) r_rdata1 <= mem_rdata;
            else         r_rdata0 <= mem_rdata;
          end
          r_done0 <= ~r_owner;
          r_done1 <= r_owner;
        end
        default: ;
      endcase
    end
  end

  assign gnt0      = r_gnt0;
  assign gnt1      = r_gnt1;
  assign done0     = r_done0;
  assign done1     = r_done1;
  assign rdata0    = r_rdata0;
  assign rdata1    = r_rdata1;
  assign busy      = (r_state != StIdle);
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_write = r_mem_write;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios then random two-master traffic, every cycle compared
// against a transaction-level timeline model with its own copy of memory contents.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req0, req1, we0, we1;
  logic [15:0] addr0, addr1;
  logic [31:0] wdata0, wdata1;
  logic        gnt0, gnt1, done0, done1, busy, mem_write;
  logic [31:0] rdata0, rdata1, mem_wdata, mem_rdata;
  logic [15:0] mem_addr;

  mem_arbiter #(.BITS_DATA(32), .BITS_ADDR(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .req0      (req0),
    .req1      (req1),
    .we0       (we0),
    .we1       (we1),
    .addr0     (addr0),
    .addr1     (addr1),
    .wdata0    (wdata0),
    .wdata1    (wdata1),
    .gnt0      (gnt0),
    .gnt1      (gnt1),
    .done0     (done0),
    .done1     (done1),
    .rdata0    (rdata0),
    .rdata1    (rdata1),
    .busy      (busy),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_write (mem_write),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory attached to the DUT pins: registered read, write on the clock edge
  logic [31:0] env_mem [0:65535];
  always @(posedge clk) begin
    if (mem_write) env_mem[mem_addr] <= mem_wdata;
    mem_rdata <= env_mem[mem_addr];
  end

  // Reference model: an access granted for cycle G shows gnt in G, busy in G..G+2, done in G+2
  logic [31:0] model_mem [0:65535];
  int          cyc;
  int          last_grant;
  logic        m_prio, m_owner, m_we;
  logic [15:0] m_addr;
  logic [31:0] m_wdata, m_rd_val;
  logic [31:0] m_rdata [2];
  int          n_cmp, n_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s cycle %0d: observed %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s cycle %0d: observed %b expected %b", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    last_grant = -100;
    m_prio     = 1'b0;
    m_owner    = 1'b0;
    m_we       = 1'b0;
    m_addr     = '0;
    m_wdata    = '0;
    m_rd_val   = '0;
    m_rdata[0] = '0;
    m_rdata[1] = '0;
  endtask

  task automatic check_outputs();
    logic in_acc;
    in_acc = (cyc >= last_grant) && (cyc <= last_grant + 2);
    chk1("gnt0", gnt0, (cyc == last_grant) && !m_owner);
    chk1("gnt1", gnt1, (cyc == last_grant) && m_owner);
    chk1("done0", done0, (cyc == last_grant + 2) && !m_owner);
    chk1("done1", done1, (cyc == last_grant + 2) && m_owner);
    chk1("busy", busy, in_acc);
    chk1("mem_write", mem_write, (cyc == last_grant) && m_we);
    chk("mem_addr", {16'h0, mem_addr}, {16'h0, m_addr});
    chk("mem_wdata", mem_wdata, m_wdata);
    chk("rdata0", rdata0, m_rdata[0]);
    chk("rdata1", rdata1, m_rdata[1]);
  endtask

  // Advance one clock: apply model effects of the coming edge, then check the new cycle
  task automatic tick();
    logic w;
    if (reset) begin
      if (cyc == last_grant && m_we) model_mem[m_addr] = m_wdata;
      if (cyc == last_grant + 1 && !m_we) m_rdata[m_owner] = m_rd_val;
      if (cyc >= last_grant + 3 && (req0 || req1)) begin
        w          = (req0 && req1) ? m_prio : req1;
        m_owner    = w;
        m_prio     = ~w;
        last_grant = cyc + 1;
        m_we       = w ? we1 : we0;
        m_addr     = w ? addr1 : addr0;
        m_wdata    = w ? wdata1 : wdata0;
        m_rd_val   = model_mem[m_addr];
      end
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
    check_outputs();
  endtask

  task automatic set_port(input logic p, input logic r, input logic w, input logic [15:0] a,
                          input logic [31:0] d);
    if (p) begin
      req1 = r; we1 = w; addr1 = a; wdata1 = d;
    end else begin
      req0 = r; we0 = w; addr0 = a; wdata0 = d;
    end
  endtask

  task automatic access(input logic p, input logic w, input logic [15:0] a, input logic [31:0] d,
                        output int wait_cyc);
    set_port(p, 1'b1, w, a, d);
    wait_cyc = 0;
    do begin
      tick();
      wait_cyc++;
    end while (!(p ? gnt1 : gnt0) && wait_cyc < 20);
    chk1("grant_seen", p ? gnt1 : gnt0, 1'b1);
    set_port(p, 1'b0, 1'($urandom), 16'($urandom), $urandom);
    repeat (3) tick();
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    model_reset();
    #1 check_outputs();
    tick();
    reset = 1'b1;
  endtask

  initial begin
    int   wc;
    int   gq[$];
    logic pend [2];
    for (int i = 0; i < 65536; i++) begin
      env_mem[i]   = 32'(i) * 32'h9E37_79B9;
      model_mem[i] = 32'(i) * 32'h9E37_79B9;
    end
    n_cmp = 0;
    n_err = 0;
    cyc   = 0;
    model_reset();

    // Reset held with both ports requesting: nothing may be granted
    set_port(1'b0, 1'b1, 1'b0, 16'h0003, 32'h0);
    set_port(1'b1, 1'b1, 1'b0, 16'h0004, 32'h0);
    @(negedge clk);
    check_outputs();
    repeat (2) tick();
    reset = 1'b1;
    tick();
    chk1("first_grant_port0", gnt0, 1'b1);
    chk1("first_grant_not_port1", gnt1, 1'b0);
    set_port(1'b0, 1'b0, 1'b0, 16'h0, 32'h0);
    set_port(1'b1, 1'b0, 1'b0, 16'h0, 32'h0);
    repeat (3) tick();

    // Write then read back through port 0
    access(1'b0, 1'b1, 16'h0010, 32'hDEADBEEF, wc);
    access(1'b0, 1'b0, 16'h0010, 32'h0, wc);
    chk("wr_rd_data", rdata0, 32'hDEADBEEF);

    // Both ports requesting continuously from a fresh prio
    pulse_reset();
    set_port(1'b0, 1'b1, 1'b0, 16'h0020, 32'h0);
    set_port(1'b1, 1'b1, 1'b0, 16'h0021, 32'h0);
    for (int i = 0; i < 16; i++) begin
      tick();
      chk1("gnt_overlap", gnt0 & gnt1, 1'b0);
      if (gnt0) gq.push_back(i * 10 + 0);
      if (gnt1) gq.push_back(i * 10 + 1);
    end
    chk("rr_count", 32'(gq.size()), 32'd4);
    if (gq.size() == 4) begin
      chk("rr_g0", 32'(gq[0]), 32'd0);
      chk("rr_g1", 32'(gq[1]), 32'd41);
      chk("rr_g2", 32'(gq[2]), 32'd80);
      chk("rr_g3", 32'(gq[3]), 32'd121);
    end
    set_port(1'b0, 1'b0, 1'b0, 16'h0, 32'h0);
    set_port(1'b1, 1'b0, 1'b0, 16'h0, 32'h0);

    // Port 1 alone at the top address, then a tie goes back to port 0
    access(1'b1, 1'b0, 16'hFFFF, 32'h0, wc);
    chk("p1_immediate", 32'(wc), 32'd1);
    chk("p1_ffff_data", rdata1, 32'hFFFF * 32'h9E37_79B9);
    set_port(1'b0, 1'b1, 1'b0, 16'h0030, 32'h0);
    set_port(1'b1, 1'b1, 1'b0, 16'h0031, 32'h0);
    tick();
    chk1("p0_wins_next", gnt0, 1'b1);
    set_port(1'b0, 1'b0, 1'b0, 16'h0, 32'h0);
    set_port(1'b1, 1'b0, 1'b0, 16'h0, 32'h0);
    repeat (3) tick();

    // Reset during ISSUE of a port 1 write aborts it
    access(1'b0, 1'b1, 16'h0005, 32'hA5A50001, wc);
    set_port(1'b1, 1'b1, 1'b1, 16'h0005, 32'h00001234);
    tick();
    chk1("abort_gnt1", gnt1, 1'b1);
    chk1("abort_write_before", mem_write, 1'b1);
    reset = 1'b0;
    model_reset();
    #1;
    chk1("abort_mem_write", mem_write, 1'b0);
    check_outputs();
    set_port(1'b1, 1'b0, 1'b0, 16'h0, 32'h0);
    repeat (3) tick();
    reset = 1'b1;
    access(1'b0, 1'b0, 16'h0005, 32'h0, wc);
    chk("abort_old_value", rdata0, 32'hA5A50001);

    // Request fields changing after acceptance are ignored
    set_port(1'b0, 1'b1, 1'b0, 16'h0001, 32'h0);
    tick();
    tick();
    set_port(1'b0, 1'b0, 1'b0, 16'h0002, 32'h0);
    tick();
    chk1("late_done0", done0, 1'b1);
    chk("late_addr", {16'h0, mem_addr}, 32'h0001);
    chk("late_rdata", rdata0, 32'h0001 * 32'h9E37_79B9);
    tick();

    // Random traffic: each master holds its command until granted
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    for (int i = 0; i < 600; i++) begin
      for (int p = 0; p < 2; p++) begin
        if (pend[p] && (p == 1 ? gnt1 : gnt0)) begin
          pend[p] = 1'b0;
          set_port(1'(p), 1'b0, 1'($urandom), 16'($urandom), $urandom);
        end else if (!pend[p] && $urandom_range(0, 2) == 0) begin
          pend[p] = 1'b1;
          set_port(1'(p), 1'b1, 1'($urandom),
                   ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom_range(0, 15)),
                   $urandom);
        end
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
